// File: rtl/operand_pkg.sv
// Shared types and constants for the operand skid buffer: beat layout,
// buffer state encoding and the state-to-occupancy mapping.
package operand_pkg;

    localparam int OPND_WIDTH = 8;
    localparam int OPND_TAG_W = 1;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } skid_state_t;

    typedef struct packed {
        logic [OPND_TAG_W-1:0] tag;
        logic [OPND_WIDTH-1:0] data;
    } opnd_beat_t;

    // Number of entries held in a given state.
    function automatic logic [1:0] occ_of(skid_state_t st);
        case (st)
            ONE:     occ_of = 2'd1;
            TWO:     occ_of = 2'd2;
            default: occ_of = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/opnd_beat_reg.sv
// Load-enabled register holding one operand beat (data plus source tag).
module opnd_beat_reg
    import operand_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  opnd_beat_t d,
    output opnd_beat_t q
);

    opnd_beat_t beat_q;

    // Capture a new beat on load; only reset clears the stored contents.
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    // NOTE: the data is reset here on purpose, so out_data/out_tag read zero after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_q <= '0;
        end else if (load) begin
            beat_q <= d;
        end
    end

    assign q = beat_q;

endmodule

// File: rtl/operand_skid_buffer.sv
// Registered valid/ready stage between the 8-bit multiplexor and the ALU
// operand port. A main register (head) and a skid register give full
// throughput while keeping in_ready a pure register output.
module operand_skid_buffer
    import operand_pkg::*;
#(
    parameter int WIDTH = OPND_WIDTH,
    parameter int TAG_W = OPND_TAG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       occupancy
);

    skid_state_t state_q, state_d;
    logic        in_ready_q;
    logic [1:0]  occ_q;

    opnd_beat_t  in_beat, m_d, m_q, s_q;
    logic        m_load, s_load;
    logic        push, pop;

    assign in_beat.data = in_data;
    assign in_beat.tag  = in_tag;

    assign push = in_valid & in_ready_q;
    assign pop  = (state_q != EMPTY) & out_ready;

    // Next state and register load enables; flush discards any push or pop.
    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        m_load  = 1'b0;
        s_load  = 1'b0;
        m_d     = in_beat;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d = ONE;
                        m_load  = 1'b1;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        m_load = 1'b1;
                    end else if (push) begin
                        state_d = TWO;
                        s_load  = 1'b1;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state_d = ONE;
                        m_load  = 1'b1;
                        m_d     = s_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // State, registered ready and occupancy all advance together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b0;
            occ_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != TWO);
            occ_q      <= occ_of(state_d);
        end
    end

    opnd_beat_reg u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (m_load),
        .d     (m_d),
        .q     (m_q)
    );

    opnd_beat_reg u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (s_load),
        .d     (in_beat),
        .q     (s_q)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = m_q.data;
    assign out_tag   = m_q.tag;
    assign occupancy = occ_q;

endmodule
